// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and
// default timeout / counter widths used by the stall controller.
package pipeline_stall_controller_pkg;

    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 16;

    // Wide enough for the largest legal MEM_TIMEOUT (255).
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/memory status in, pipeline hold/squash controls out.
// master: pipeline side (drives status); slave: stall controller.
interface pipeline_stall_controller_if;

    logic has_hazard;
    logic branch_taken;
    logic mem_req;
    logic sram_ready;

    logic freeze_all;
    logic stall_if;
    logic bubble_id_exe;
    logic flush_if_id;

    modport master (
        output has_hazard, branch_taken, mem_req, sram_ready,
        input  freeze_all, stall_if, bubble_id_exe, flush_if_id
    );

    modport slave (
        input  has_hazard, branch_taken, mem_req, sram_ready,
        output freeze_all, stall_if, bubble_id_exe, flush_if_id
    );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating event counter: sync active-low reset, clr wins over inc.
// Ports: clk, rst_n, clr, inc, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/freeze controller with memory-timeout FSM.
// Ports: clk, rst_n, cnt_clr, ctl (slave), mem_error, *_cnt.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cnt_clr,
    pipeline_stall_controller_if.slave  ctl,
    output logic                        mem_error,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            freeze_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e       state;
    ctrl_state_e       state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              freeze;
    logic              flush;
    logic              stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // wait_cnt counts frozen cycles already spent, so the request
    // cycle in RUN loads 1 and the timeout fires on the cycle that
    // would be frozen cycle number MEM_TIMEOUT.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        freeze    = 1'b0;
        unique case (state)
            RUN: begin
                if (ctl.mem_req && !ctl.sram_ready) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (ctl.sram_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERROR;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Freeze dominates, then branch flush, then hazard stall.
    assign flush = ctl.branch_taken & ~freeze;
    assign stall = ctl.has_hazard & ~ctl.branch_taken & ~freeze;

    assign ctl.freeze_all    = freeze;
    assign ctl.flush_if_id   = flush;
    assign ctl.stall_if      = stall;
    assign ctl.bubble_id_exe = stall | flush;

    assign mem_error = (state == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (freeze),
        .count (freeze_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: small-parameter and default
// instances, vector table, scoreboard model, hand corner sequences.
module tb_pipeline_stall_controller;

    logic clk;
    logic rst_n;
    logic cnt_clr;

    pipeline_stall_controller_if bus_s ();
    pipeline_stall_controller_if bus_d ();

    logic        err_s;
    logic        err_d;
    logic [3:0]  sc_s, fc_s, lc_s;
    logic [15:0] sc_d, fc_d, lc_d;

    pipeline_stall_controller #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_clr    (cnt_clr),
        .ctl        (bus_s),
        .mem_error  (err_s),
        .stall_cnt  (sc_s),
        .freeze_cnt (fc_s),
        .flush_cnt  (lc_s)
    );

    pipeline_stall_controller dut_d (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_clr    (cnt_clr),
        .ctl        (bus_d),
        .mem_error  (err_d),
        .stall_cnt  (sc_d),
        .freeze_cnt (fc_d),
        .flush_cnt  (lc_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {freeze, stall_if, bubble, flush, mem_error}
    logic [4:0] o_s, o_d;
    assign o_s = {bus_s.freeze_all, bus_s.stall_if,
                  bus_s.bubble_id_exe, bus_s.flush_if_id, err_s};
    assign o_d = {bus_d.freeze_all, bus_d.stall_if,
                  bus_d.bubble_id_exe, bus_d.flush_if_id, err_d};

    typedef struct packed {
        logic r, h, b, m, s, c;
    } in_t;

    typedef struct packed {
        logic [4:0]  o;
        logic [15:0] sc, fc, lc;
    } exp_t;

    typedef struct {
        int st; int wc; int sc; int fc; int lc;
    } mdl_t;

    typedef struct packed {
        in_t        i;
        logic [4:0] o;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    mdl_t ms, md;
    exp_t q_s[$];
    exp_t q_d[$];
    vec_t tbl[12];

    function automatic exp_t m_out(mdl_t m, in_t i);
        exp_t e;
        logic f, st, fl;
        f  = (m.st == 0 && i.m && !i.s) || (m.st == 1 && !i.s)
             || m.st == 2;
        fl = i.b && !f;
        st = i.h && !i.b && !f;
        e.o  = {f, st, st | fl, fl, logic'(m.st == 2)};
        e.sc = 16'(m.sc);
        e.fc = 16'(m.fc);
        e.lc = 16'(m.lc);
        return e;
    endfunction

    function automatic mdl_t m_next(mdl_t m, in_t i, int tmo, int cmax);
        mdl_t n;
        exp_t e;
        n = m;
        e = m_out(m, i);
        if (!i.r) begin
            n = '{0, 0, 0, 0, 0};
            return n;
        end
        if (i.c) begin
            n.sc = 0; n.fc = 0; n.lc = 0;
        end else begin
            if (e.o[3] && n.sc < cmax) n.sc++;
            if (e.o[4] && n.fc < cmax) n.fc++;
            if (e.o[1] && n.lc < cmax) n.lc++;
        end
        case (m.st)
            0: if (i.m && !i.s) begin n.st = 1; n.wc = 1; end
            1: begin
                if (i.s) begin
                    n.st = 0; n.wc = 0;
                end else if (m.wc == tmo - 1) begin
                    n.st = 2;
                end else begin
                    n.wc = m.wc + 1;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time,
                     act, exp);
        end
    endtask

    // Drive one cycle just after the rising edge; push model outputs
    // for the scoreboard, then advance the model across the next edge.
    task automatic step(input logic r, h, b, m, s, c);
        in_t i;
        @(posedge clk);
        #1;
        i = {r, h, b, m, s, c};
        rst_n = r;
        cnt_clr = c;
        bus_s.has_hazard = h; bus_s.branch_taken = b;
        bus_s.mem_req = m;    bus_s.sram_ready = s;
        bus_d.has_hazard = h; bus_d.branch_taken = b;
        bus_d.mem_req = m;    bus_d.sram_ready = s;
        q_s.push_back(m_out(ms, i));
        q_d.push_back(m_out(md, i));
        ms = m_next(ms, i, 4, 15);
        md = m_next(md, i, 64, 65535);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("rst_s", {o_s, sc_s, fc_s, lc_s}, 0);
        chk("rst_d", {o_d, sc_d, fc_d, lc_d}, 0);
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            a = {o_s, 12'(0), sc_s, 12'(0), fc_s, 12'(0), lc_s};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL sb_s t=%0t got=%h want=%h", $time, a, e);
            end
        end
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            a = {o_d, sc_d, fc_d, lc_d};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL sb_d t=%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        bus_s.has_hazard = 0; bus_s.branch_taken = 0;
        bus_s.mem_req = 0;    bus_s.sram_ready = 0;
        bus_d.has_hazard = 0; bus_d.branch_taken = 0;
        bus_d.mem_req = 0;    bus_d.sram_ready = 0;
        ms = '{0, 0, 0, 0, 0};
        md = '{0, 0, 0, 0, 0};

        //          r h b m s c    f s b l e
        tbl[0]  = {6'b1_0_0_0_0_0, 5'b0_0_0_0_0};
        tbl[1]  = {6'b1_1_0_0_0_0, 5'b0_1_1_0_0};
        tbl[2]  = {6'b1_0_1_0_0_0, 5'b0_0_1_1_0};
        tbl[3]  = {6'b1_1_1_0_0_0, 5'b0_0_1_1_0};
        tbl[4]  = {6'b1_0_0_1_1_0, 5'b0_0_0_0_0};
        tbl[5]  = {6'b1_1_1_1_1_0, 5'b0_0_1_1_0};
        tbl[6]  = {6'b1_1_1_1_0_0, 5'b1_0_0_0_0};
        tbl[7]  = {6'b1_1_0_0_0_0, 5'b1_0_0_0_0};
        tbl[8]  = {6'b1_0_1_0_1_0, 5'b0_0_1_1_0};
        tbl[9]  = {6'b1_0_0_0_0_0, 5'b0_0_0_0_0};
        tbl[10] = {6'b1_0_0_1_0_1, 5'b1_0_0_0_0};
        tbl[11] = {6'b1_1_0_0_1_0, 5'b0_1_1_0_0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].i.r, tbl[i].i.h, tbl[i].i.b,
                 tbl[i].i.m, tbl[i].i.s, tbl[i].i.c);
            at_neg();
            chk($sformatf("tbl_s[%0d]", i), o_s, tbl[i].o);
            chk($sformatf("tbl_d[%0d]", i), o_d, tbl[i].o);
        end

        // Two hazard cycles.
        do_reset();
        repeat (2) begin
            step(1, 1, 0, 0, 0, 0);
            at_neg();
            chk("haz_out", {o_s[3:2], o_d[3:2]}, 4'b1111);
        end
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("haz_cnt_s", sc_s, 2);
        chk("haz_cnt_d", sc_d, 2);

        // Branch beats hazard.
        do_reset();
        step(1, 1, 1, 0, 0, 0);
        at_neg();
        chk("br_out", o_s[3:1], 3'b011);
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("br_cnt", {lc_s, sc_s}, 8'h10);

        // Three-cycle memory stall with hazard held high.
        do_reset();
        repeat (3) begin
            step(1, 1, 0, 1, 0, 0);
            at_neg();
            chk("mem_frz", {o_s[4:3], o_d[4:3]}, 4'b1010);
        end
        step(1, 1, 0, 1, 1, 0);
        at_neg();
        chk("mem_rel", {o_s[4:3], o_d[4:3]}, 4'b0101);
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("mem_run", {o_s[4], o_d[4]}, 2'b00);
        chk("mem_fcnt_s", fc_s, 3);
        chk("mem_fcnt_d", fc_d, 3);
        chk("mem_scnt_s", sc_s, 1);

        // Timeout into ERROR, saturation, then reset recovery.
        do_reset();
        for (int k = 0; k < 70; k++) begin
            step(1, 0, 0, 1, 0, 0);
            at_neg();
            chk($sformatf("to_s[%0d]", k), {err_s, o_s[4]},
                {logic'(k >= 4), 1'b1});
            chk($sformatf("to_d[%0d]", k), {err_d, o_d[4]},
                {logic'(k >= 64), 1'b1});
        end
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("err_hold", {o_s[4], err_s}, 2'b11);
        chk("err_fcnt_s", fc_s, 15);
        chk("err_fcnt_d", fc_d, 70);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("err_rst_s", {o_s, sc_s, fc_s, lc_s}, 0);
        chk("err_rst_d", {o_d, sc_d, fc_d, lc_d}, 0);

        // Saturation and clear-over-increment.
        do_reset();
        repeat (20) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("sat_s", sc_s, 15);
        chk("sat_d", sc_d, 20);
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("clr_s", sc_s, 0);
        chk("clr_d", sc_d, 0);

        if (q_s.size() != 0 || q_d.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain left=%0d want=0",
                     q_s.size() + q_d.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, 64, maximum consecutive memory-freeze cycles before error (range 2..255).
REQ-002 Parameter: CNT_W, 16, width of each performance counter.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: has_hazard  input  1  RAW hazard flag from the hazard detection unit (ID stage).
REQ-006 Port: branch_taken  input  1  branch resolved taken in EXE stage.
REQ-007 Port: mem_req  input  1  MEM stage holds a load or store (MEM_R_EN or MEM_W_EN).
REQ-008 Port: sram_ready  input  1  memory access in MEM stage completes this cycle.
REQ-009 Port: cnt_clr  input  1  clears all performance counters.
REQ-010 Port: freeze_all  output  1  hold every pipeline register and the PC.
REQ-011 Port: stall_if  output  1  hold PC and IF/ID register.
REQ-012 Port: bubble_id_exe  output  1  load NOP into ID/EXE register.
REQ-013 Port: flush_if_id  output  1  squash IF/ID register.
REQ-014 Port: mem_error  output  1  sticky memory-timeout flag.
REQ-015 Port: stall_cnt, freeze_cnt, flush_cnt  output  CNT_W each  hazard-stall, memory-freeze, branch-flush cycle counts.

Function
REQ-016 FSM states SHALL be RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-017 RUN -> MEM_WAIT when mem_req=1 and sram_ready=0; otherwise stay RUN.
REQ-018 MEM_WAIT -> RUN on the edge where sram_ready=1; mem_req is ignored in MEM_WAIT.
REQ-019 MEM_WAIT -> ERROR when sram_ready=0 and wait_cnt=MEM_TIMEOUT-1; ERROR is left only by reset.
REQ-020 wait_cnt SHALL be 0 in RUN, increment by 1 on each frozen cycle (including the RUN entry cycle), and clear on return to RUN.
REQ-021 freeze_all SHALL be combinational: 1 when (RUN and mem_req and !sram_ready), (MEM_WAIT and !sram_ready), or ERROR.
REQ-022 A stall sequence with sram_ready arriving after N low cycles SHALL assert freeze_all for exactly N cycles; sram_ready=1 in the request cycle gives zero freeze.
REQ-023 Priority SHALL be freeze_all > branch_taken > has_hazard.
REQ-024 flush_if_id = bubble_id_exe-flush term = branch_taken and !freeze_all.
REQ-025 stall_if = has_hazard and !branch_taken and !freeze_all; bubble_id_exe = stall_if or flush term.
REQ-026 mem_error SHALL be 1 exactly while in ERROR.
REQ-027 Counters SHALL increment by 1 per cycle their event output is 1 (stall_if, freeze_all, flush_if_id), saturate at all-ones, never wrap.
REQ-028 cnt_clr=1 SHALL zero all counters on the next edge, overriding a same-cycle increment.
REQ-029 Counters SHALL continue counting freeze_all cycles in ERROR until saturation.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force state RUN, wait_cnt=0, all counters 0, mem_error=0, regardless of state including ERROR or MEM_WAIT.
REQ-031 During reset, with inputs low, all outputs SHALL be 0; combinational outputs follow REQ-021..025 from reset state.

Structure
REQ-032 State encodings (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2) and default MEM_TIMEOUT/CNT_W SHALL live in the shared pipeline control define/package file.
REQ-033 One sub-module sat_counter (parameter W; ports clk, rst_n, clr, inc, count) SHALL be instantiated three times for the performance counters.

Verification
REQ-034 has_hazard=1 for 2 cycles, others 0 -> stall_if=1 and bubble_id_exe=1 for 2 cycles, stall_cnt=2.
REQ-035 branch_taken=1 and has_hazard=1 same cycle -> flush_if_id=1, bubble_id_exe=1, stall_if=0, flush_cnt=1, stall_cnt=0.
REQ-036 mem_req=1, sram_ready low 3 cycles then high, has_hazard=1 throughout -> freeze_all=1 for 3 cycles, stall_if=0 during them, state back to RUN, freeze_cnt=3.
REQ-037 MEM_TIMEOUT=4, mem_req=1, sram_ready=0 forever -> ERROR after 4 frozen cycles, mem_error=1, freeze_all stays 1; rst_n=0 one edge -> all outputs 0.
REQ-038 CNT_W=4, has_hazard=1 for 20 cycles -> stall_cnt holds 15; cnt_clr=1 with has_hazard=1 -> stall_cnt=0 next cycle.
